// File: rtl/encoder_frontend.sv
// Purpose : conditions one raw quadrature encoder into a saturating/wrapping colour level.
// Latency : at most 4 + DEBOUNCE_LEN*DEBOUNCE_DIV cycles from a settled A rise to level/pulse.
// Backpressure: none; the level updates unconditionally and the pulses are not held.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous reset, active low (synchronous release expected upstream)
//   enc_a      raw encoder A pin, asynchronous and bouncy
//   enc_b      raw encoder B pin, asynchronous and bouncy
//   level      registered WIDTH-bit colour level
//   step_up    one-cycle pulse when an up detent was applied (also when clamped)
//   step_down  one-cycle pulse when a down detent was applied (also when clamped)
module encoder_frontend #(
    parameter int WIDTH        = 8,
    parameter int DEBOUNCE_DIV = 16,
    parameter int DEBOUNCE_LEN = 3,
    parameter int STEP         = 1,
    parameter int WRAP         = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [WIDTH-1:0] level,
    output logic             step_up,
    output logic             step_down
);

    localparam int DIV_W = (DEBOUNCE_DIV > 2) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int LEN_W = (DEBOUNCE_LEN > 2) ? $clog2(DEBOUNCE_LEN) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DEBOUNCE_DIV - 1);
    // The agreement count only ever holds 0..LEN-1: the sample that would
    // bring it to LEN flips the debounced value and clears it instead.
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(DEBOUNCE_LEN - 1);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] LVL_MAX  = {WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Two-flop synchronisers, one pair per pin
    // ------------------------------------------------------------------
    logic       r_a_meta;
    logic       r_a_s;
    logic       r_b_meta;
    logic       r_b_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_meta <= 1'b0;
            r_a_s    <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_s    <= 1'b0;
        end else begin
            r_a_meta <= enc_a;
            r_a_s    <= r_a_meta;
            r_b_meta <= enc_b;
            r_b_s    <= r_b_meta;
        end
    end

    // ------------------------------------------------------------------
    // Free-running sample strobe, one cycle in every DEBOUNCE_DIV
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_strobe;

    assign w_strobe = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (w_strobe) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Debounce, index 0 = A, index 1 = B. A level is accepted only after
    // DEBOUNCE_LEN consecutive strobe samples all disagree with the
    // current debounced value; any agreeing sample restarts the run.
    // ------------------------------------------------------------------
    logic [1:0]       w_sync;
    logic [1:0]       r_deb;
    logic [LEN_W-1:0] r_agree [2];

    assign w_sync = {r_b_s, r_a_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_agree[i] <= '0;
            end
        end else if (w_strobe) begin
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] != r_deb[i]) begin
                    if (r_agree[i] == LEN_LAST) begin
                        r_deb[i]   <= w_sync[i];
                        r_agree[i] <= '0;
                    end else begin
                        r_agree[i] <= r_agree[i] + LEN_W'(1);
                    end
                end else begin
                    r_agree[i] <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // x1 decode: only a rising edge of debounced A is a detent; B at that
    // moment picks the direction. The previous-A flop resets to 0 like
    // the debounced value, so reset itself never looks like an edge.
    // ------------------------------------------------------------------
    logic r_a_prev;
    logic w_detent;
    logic w_down;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_prev <= 1'b0;
        end else begin
            r_a_prev <= r_deb[0];
        end
    end

    assign w_detent = r_deb[0] & ~r_a_prev;
    assign w_down   = r_deb[1];

    // ------------------------------------------------------------------
    // Level arithmetic at WIDTH+1 bits: the extra bit is the carry on
    // the way up and the borrow on the way down.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_up_lvl;
    logic [WIDTH-1:0] w_dn_lvl;

    assign w_sum  = {1'b0, level} + STEP_EXT;
    assign w_diff = {1'b0, level} - STEP_EXT;

    always_comb begin
        w_up_lvl = w_sum[WIDTH-1:0];
        w_dn_lvl = w_diff[WIDTH-1:0];
        if (WRAP == 0) begin
            if (w_sum[WIDTH]) begin
                w_up_lvl = LVL_MAX;
            end
            if (w_diff[WIDTH]) begin
                w_dn_lvl = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level     <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
        end else begin
            step_up   <= w_detent & ~w_down;
            step_down <= w_detent &  w_down;
            if (w_detent) begin
                level <= w_down ? w_dn_lvl : w_up_lvl;
            end
        end
    end

endmodule

// File: tb/tb_encoder_frontend.sv
`timescale 1ns/1ps
module tb_encoder_frontend;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enc_a;
    logic       enc_b;
    logic [7:0] lvl0;
    logic [7:0] lvl1;
    logic [7:0] lvl2;
    logic [2:0] up_v;
    logic [2:0] dn_v;

    always #5 clk = ~clk;

    // Three flavours on the same pins: saturating step 1, wrapping step 1,
    // saturating step 16.
    encoder_frontend #(.WIDTH(8), .DEBOUNCE_DIV(4), .DEBOUNCE_LEN(3), .STEP(1), .WRAP(0)) u_sat (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .level(lvl0), .step_up(up_v[0]), .step_down(dn_v[0]));
    encoder_frontend #(.WIDTH(8), .DEBOUNCE_DIV(4), .DEBOUNCE_LEN(3), .STEP(1), .WRAP(1)) u_wrap (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .level(lvl1), .step_up(up_v[1]), .step_down(dn_v[1]));
    encoder_frontend #(.WIDTH(8), .DEBOUNCE_DIV(4), .DEBOUNCE_LEN(3), .STEP(16), .WRAP(0)) u_s16 (
        .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
        .level(lvl2), .step_up(up_v[2]), .step_down(dn_v[2]));

    typedef struct {
        bit down;
        int lvl;
        int t;
    } exp_t;

    typedef struct {
        bit do_reset;
        bit down;
        int n;
        int hold;
        int exp0;
        int exp1;
        int exp2;
    } row_t;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mdl [3];
    exp_t sb  [3][$];
    row_t tbl [6];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lvl_of(input int i);
        case (i)
            0:       return int'(lvl0);
            1:       return int'(lvl1);
            default: return int'(lvl2);
        endcase
    endfunction

    // Reference behaviour per instance
    function automatic int next_lvl(input int i, input int cur, input bit down);
        int s;
        int r;
        s = (i == 2) ? 16 : 1;
        r = down ? cur - s : cur + s;
        if (i == 1) return r & 255;
        if (r < 0) return 0;
        if (r > 255) return 255;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_detent(input bit down);
        for (int i = 0; i < 3; i++) begin
            mdl[i] = next_lvl(i, mdl[i], down);
            sb[i].push_back('{down, mdl[i], cyc});
        end
    endtask

    task automatic check_levels(input string name, input int e0, input int e1, input int e2);
        chk(name, 0, lvl_of(0), e0);
        chk(name, 1, lvl_of(1), e1);
        chk(name, 2, lvl_of(2), e2);
    endtask

    task automatic check_drained();
        for (int i = 0; i < 3; i++) chk("pending_pulses", i, sb[i].size(), 0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            sb[i].delete();
            mdl[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_model();
        #1;
        check_levels("reset_level", 0, 0, 0);
        chk("reset_pulses", 0, int'(up_v | dn_v), 0);
        wait_cyc(3);
        reset_n = 1'b1;
    endtask

    task automatic detent(input bit down, input int hold);
        if (enc_b != down) begin
            enc_b = down;
            wait_cyc(hold);
        end
        enc_a = 1'b1;
        push_detent(down);
        wait_cyc(hold);
        enc_a = 1'b0;
        wait_cyc(hold);
    endtask

    // Output monitor: every pulse must match the oldest expected detent
    task automatic monitor(input int i, input bit u, input bit d);
        exp_t e;
        int   lat;
        if (u && d) begin
            checks++;
            failures++;
            $display("FAIL both_pulses inst=%0d actual=up+down required=one", i);
        end
        if (u || d) begin
            if (sb[i].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse inst=%0d actual=up%0d/down%0d level=%0d required=none",
                         i, u, d, lvl_of(i));
            end else begin
                e = sb[i].pop_front();
                chk("pulse_dir_down", i, int'(d), int'(e.down));
                chk("pulse_level", i, lvl_of(i), e.lvl);
                lat = cyc - e.t;
                checks++;
                if (lat > 16 || lat < 8) begin
                    failures++;
                    $display("FAIL latency inst=%0d actual=%0d required=8..16", i, lat);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            for (int i = 0; i < 3; i++) monitor(i, up_v[i], dn_v[i]);
        end
    end

    initial begin
        //           rst dn  n    hold exp0 exp1 exp2
        tbl[0] = '{0, 0, 5,   40, 5,   5,   80};
        tbl[1] = '{1, 0, 254, 20, 254, 254, 255};
        tbl[2] = '{0, 0, 3,   20, 255, 1,   255};
        tbl[3] = '{0, 1, 2,   20, 253, 255, 223};
        tbl[4] = '{1, 1, 3,   20, 0,   253, 0};
        tbl[5] = '{0, 0, 2,   20, 2,   255, 32};

        reset_n = 1'b0;
        enc_a   = 1'b0;
        enc_b   = 1'b0;
        clear_model();
        wait_cyc(1);

        // Reset held with arbitrary pin activity: outputs stay cleared
        for (int k = 0; k < 20; k++) begin
            enc_a = 1'($urandom_range(0, 1));
            enc_b = 1'($urandom_range(0, 1));
            wait_cyc(1);
            if (k % 5 == 0) begin
                check_levels("in_reset_level", 0, 0, 0);
                chk("in_reset_pulses", 0, int'(up_v | dn_v), 0);
            end
        end
        enc_a = 1'b0;
        enc_b = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(200);
        check_levels("idle_level", 0, 0, 0);

        // Table-driven detent runs
        for (int r = 0; r < 6; r++) begin
            if (tbl[r].do_reset) do_reset();
            for (int n = 0; n < tbl[r].n; n++) detent(tbl[r].down, tbl[r].hold);
            wait_cyc(20);
            check_levels("row_level", tbl[r].exp0, tbl[r].exp1, tbl[r].exp2);
            check_drained();
        end

        // Bouncing A with B=1: one down detent only, once A settles high
        do_reset();
        enc_b = 1'b1;
        wait_cyc(40);
        for (int k = 0; k < 10; k++) begin
            enc_a = ~enc_a;
            wait_cyc(3);
        end
        enc_a = 1'b1;
        push_detent(1'b1);
        wait_cyc(40);
        enc_a = 1'b0;
        wait_cyc(40);
        check_levels("bounce_level", 0, 255, 0);
        check_drained();
        enc_b = 1'b0;
        wait_cyc(40);

        // Reset in the middle of debouncing an A rise, A held through release
        do_reset();
        wait_cyc(20);
        enc_a = 1'b1;
        wait_cyc(6);
        reset_n = 1'b0;
        clear_model();
        #1;
        check_levels("mid_reset_level", 0, 0, 0);
        wait_cyc(3);
        reset_n = 1'b1;
        push_detent(1'b0);
        wait_cyc(40);
        check_levels("post_reset_level", 1, 1, 16);
        enc_a = 1'b0;
        wait_cyc(40);
        check_levels("post_reset_final", 1, 1, 16);
        check_drained();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
